// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath and the output layer: FSM
// state encoding, default widths and the accumulator-to-sum saturation.
package nn_pkg;

    // Phases of one vector: accumulate, saturate, LUT read, present result.
    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_SAT = 2'd1,
        ST_LUT = 2'd2,
        ST_OUT = 2'd3
    } state_t;

    // Default widths shared by every neuron instance.
    localparam int DEF_IN_W       = 8;
    localparam int DEF_WEIGHT_W   = 8;
    localparam int DEF_ACC_W      = 32;
    localparam int DEF_SUM_W      = 16;
    localparam int DEF_LUT_ADDR_W = 8;
    localparam int DEF_OUT_W      = 8;

    // Clamp a sign-extended accumulator value into the signed sum_w range.
    // Callers keep the low sum_w bits of the result.
    function automatic longint saturate(input longint value, input int sum_w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (sum_w - 1)) - longint'(1);
        lo = -(longint'(1) <<< (sum_w - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/sigmoid_lut.sv
// Sigmoid look-up table with a one-cycle registered read. The table contents
// are computed at elaboration with integer fixed-point arithmetic, so the ROM
// image needs no external file and stays in step with the width parameters.
module sigmoid_lut
    import nn_pkg::*;
#(
    parameter int LUT_ADDR_W = DEF_LUT_ADDR_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SUM_W      = DEF_SUM_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LUT_ADDR_W-1:0] addr,
    output logic [OUT_W-1:0]      data
);

    localparam int DEPTH  = 1 << LUT_ADDR_W;
    // Fraction bits of the fixed-point exponential.
    localparam int FRAC_W = 40;

    // Entry k holds round((2^OUT_W-1) / (1 + exp(-s_k))) where
    // s_k = (k*2^(SUM_W-LUT_ADDR_W) - 2^(SUM_W-1)) / 2^(SUM_W-4).
    // exp(|s_k|) comes from a Taylor series in Q.FRAC_W; the sign of s_k
    // selects which of the two equivalent fractions is evaluated so that
    // only exp of a non-negative argument is needed.
    function automatic longint sigmoid_entry(input int k);
        longint num;
        longint m;
        longint d;
        longint one;
        longint e;
        longint t;
        longint scale;
        longint a;
        longint b;
        bit     neg;
        one = longint'(1) <<< FRAC_W;
        num = (longint'(k) <<< (SUM_W - LUT_ADDR_W)) - (longint'(1) <<< (SUM_W - 1));
        neg = (num < 0);
        m   = neg ? -num : num;
        d   = longint'(1) <<< (SUM_W - 4);
        // Cancel common powers of two so the series products stay in range.
        for (int i = 0; i < 64; i++) begin
            if (d > 16 && (m % 2) == 0) begin
                m = m / 2;
                d = d / 2;
            end
        end
        e = one;
        t = one;
        for (int n = 1; n <= 60; n++) begin
            t = (t * m) / (d * longint'(n));
            e = e + t;
        end
        scale = (longint'(1) <<< OUT_W) - longint'(1);
        if (neg) begin
            a = scale * one;
        end else begin
            a = scale * e;
        end
        b = e + one;
        // Round half up.
        return (2 * a + b) / (2 * b);
    endfunction

    logic [OUT_W-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [OUT_W-1:0] ENTRY = OUT_W'(sigmoid_entry(k));
        assign rom[k] = ENTRY;
    end

    // Registered read; output clears to 0 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential hidden-layer neuron: streams N_INPUTS unsigned elements in
// through a valid/ready port, multiply-accumulates them against a loadable
// signed weight bank, adds the bias, saturates, and returns one sigmoid
// activation per vector through a valid/ready port.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. A source holds valid and data stable until the
// transfer; in_ready is high only in the accumulate phase, and out_valid
// with out_data stays asserted and unchanged until out_ready is seen.
module neuron_mac_seq
    import nn_pkg::*;
#(
    parameter int N_INPUTS   = 37,
    parameter int IN_W       = DEF_IN_W,
    parameter int WEIGHT_W   = DEF_WEIGHT_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int SUM_W      = DEF_SUM_W,
    parameter int LUT_ADDR_W = DEF_LUT_ADDR_W,
    parameter int OUT_W      = DEF_OUT_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_W-1:0]                 in_data,
    input  logic                            w_wr_en,
    input  logic [$clog2(N_INPUTS+1)-1:0]   w_wr_addr,
    input  logic [WEIGHT_W-1:0]             w_wr_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_W-1:0]                out_data,
    output logic                            busy,
    output logic [1:0]                      fsm_state
);

    localparam int ADDR_W    = $clog2(N_INPUTS + 1);
    localparam int CNT_W     = $clog2(N_INPUTS);
    localparam int PROD_W    = IN_W + 1 + WEIGHT_W;
    localparam int ACC_MIN_W = IN_W + WEIGHT_W + $clog2(N_INPUTS) + 1;

    // The accumulator must hold a full vector of worst-case products, and
    // the saturation path sign-extends it into a 64-bit intermediate.
    if (ACC_W < ACC_MIN_W || ACC_W > 63) begin : g_acc_w_check
        $error("neuron_mac_seq: ACC_W=%0d outside [%0d, 63]", ACC_W, ACC_MIN_W);
    end

    state_t                     state;
    state_t                     state_next;
    logic [CNT_W-1:0]           count;
    logic signed [ACC_W-1:0]    acc;
    logic signed [WEIGHT_W-1:0] weights [N_INPUTS];
    logic signed [WEIGHT_W-1:0] bias;
    logic [LUT_ADDR_W-1:0]      lut_addr;
    logic                       in_hs;
    logic                       last_elem;
    logic signed [PROD_W-1:0]   prod;
    logic [SUM_W-1:0]           sat_sum;
    logic [SUM_W-1:0]           sat_offset;
    logic [CNT_W-1:0]           w_idx;

    assign in_hs     = in_valid && in_ready;
    assign last_elem = (count == CNT_W'(N_INPUTS - 1));
    assign w_idx     = w_wr_addr[CNT_W-1:0];
    assign fsm_state = state;

    // The product reads the weight register before any same-cycle write
    // lands, so a write to weight[count] only affects later vectors.
    assign prod = $signed({1'b0, in_data}) * weights[count];

    // Bias joins in the saturate phase, so a bias write during accumulation
    // still applies to the vector in flight.
    assign sat_sum    = SUM_W'(saturate(longint'(acc) + longint'(bias), SUM_W));
    // Flipping the sign bit turns two's complement into offset binary.
    assign sat_offset = sat_sum ^ {1'b1, {(SUM_W-1){1'b0}}};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accumulate until the last element, one cycle each
    // for saturate and LUT read, then hold the result until it is taken.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACC: begin
                if (in_hs && last_elem) begin
                    state_next = ST_SAT;
                end
            end
            ST_SAT: state_next = ST_LUT;
            ST_LUT: state_next = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_next = ST_ACC;
                end
            end
            default: state_next = ST_ACC;
        endcase
    end

    // Output decode; in_ready is forced low while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        in_ready  = (state == ST_ACC) && !rst;
        out_valid = (state == ST_OUT);
        busy      = (state != ST_ACC) || (count != '0);
    end

    // Accumulator, element counter and LUT address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            count    <= '0;
            lut_addr <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_hs) begin
                        acc <= acc + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
                        if (!last_elem) begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ST_SAT: begin
                    lut_addr <= sat_offset[SUM_W-1 -: LUT_ADDR_W];
                end
                ST_OUT: begin
                    if (out_ready) begin
                        acc   <= '0;
                        count <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Weight and bias bank; writes land in any state, out-of-range
    // addresses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                weights[i] <= '0;
            end
            bias <= '0;
        end else if (w_wr_en) begin
            if (w_wr_addr < ADDR_W'(N_INPUTS)) begin
                weights[w_idx] <= w_wr_data;
            end else if (w_wr_addr == ADDR_W'(N_INPUTS)) begin
                bias <= w_wr_data;
            end
        end
    end

    sigmoid_lut #(
        .LUT_ADDR_W(LUT_ADDR_W),
        .OUT_W     (OUT_W),
        .SUM_W     (SUM_W)
    ) u_sigmoid_lut (
        .clk (clk),
        .rst (rst),
        .addr(lut_addr),
        .data(out_data)
    );

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed and randomized bench for neuron_mac_seq with four inputs per
// vector. Expected activations come from a dot product in plain integer
// arithmetic followed by clamping and a real-valued sigmoid.
module tb_neuron_mac_seq;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       w_wr_en;
    logic [2:0] w_wr_addr;
    logic [7:0] w_wr_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic [1:0] fsm_state;

    int         total = 0;
    int         bad   = 0;
    int         w_m [N];
    int         bias_m;
    longint     acc_m;
    logic [7:0] exp_q [$];

    // Clock.
    always #5 clk = ~clk;

    neuron_mac_seq #(.N_INPUTS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .w_wr_en  (w_wr_en),
        .w_wr_addr(w_wr_addr),
        .w_wr_data(w_wr_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .fsm_state(fsm_state)
    );

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Sigmoid of LUT address with the default 16-bit sum and 8-bit widths.
    function automatic int sig_ref(input int addr);
        real s;
        s = (real'(addr) * 256.0 - 32768.0) / 4096.0;
        return $rtoi(255.0 / (1.0 + $exp(-s)) + 0.5);
    endfunction

    function automatic int act_ref(input longint sum);
        longint s;
        s = sum;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return sig_ref(int'((s + 32768) / 256));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) w_m[i] = 0;
        bias_m = 0;
        acc_m  = 0;
        exp_q.delete();
    endtask

    task automatic wr_w(input int addr, input int data);
        w_wr_en   = 1'b1;
        w_wr_addr = 3'(addr);
        w_wr_data = 8'(data);
        tick();
        w_wr_en = 1'b0;
        if (addr < N) w_m[addr] = data;
        else if (addr == N) bias_m = data;
    endtask

    task automatic wr_all(input int data);
        for (int i = 0; i < N; i++) wr_w(i, data);
    endtask

    // One element, optionally preceded by idle cycles carrying junk data.
    task automatic send_elem(input int idx, input int d, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
            if (idx > 0) chk("busy in gap", busy, 1);
        end
        in_valid = 1'b1;
        in_data  = 8'(d);
        guard    = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            chk("in_ready timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        acc_m += longint'(d) * longint'(w_m[idx]);
        tick();
        in_valid = 1'b0;
        if (idx == N - 1) begin
            exp_q.push_back(8'(act_ref(acc_m + longint'(bias_m))));
            acc_m = 0;
        end
    endtask

    task automatic send_vec(input int d [N], input int maxgap);
        for (int i = 0; i < N; i++) send_elem(i, d[i], $urandom_range(0, maxgap));
    endtask

    // Wait for a result, optionally stall it, then take it.
    task automatic get_out(input string tag, input int stall, input bit poke_valid);
        int         guard;
        logic [7:0] expv;
        out_ready = 1'b0;
        guard     = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        chk({tag, " valid"}, out_valid, 1);
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk(tag, out_data, expv);
        if (poke_valid) begin
            in_valid = 1'b1;
            in_data  = 8'hff;
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({tag, " hold"}, out_data, expv);
            chk({tag, " in_ready stalled"}, in_ready, 0);
            chk({tag, " busy stalled"}, busy, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " valid drop"}, out_valid, 0);
        chk({tag, " busy drop"}, busy, 0);
    endtask

    initial begin
        int v [N];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset state.
        repeat (3) tick();
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("in_ready after release", in_ready, 1);
        tick();

        // Zero inputs: latency and the LUT midpoint.
        wr_all(1);
        for (int i = 0; i < N; i++) send_elem(i, 0, 0);
        chk("latency +1", out_valid, 0);
        chk("busy +1", busy, 1);
        tick();
        chk("latency +2", out_valid, 0);
        tick();
        chk("latency +3", out_valid, 1);
        chk("midpoint value", out_data, 128);
        get_out("zero vec", 0, 0);

        // Positive and negative saturation.
        wr_all(127);
        v = '{255, 255, 255, 255};
        send_vec(v, 0);
        get_out("sat high", 0, 0);
        wr_all(-128);
        send_vec(v, 0);
        get_out("sat low", 0, 0);

        // Bias written mid-vector still applies.
        wr_all(0);
        send_elem(0, 37, 0);
        send_elem(1, 91, 0);
        wr_w(N, 100);
        send_elem(2, 5, 0);
        send_elem(3, 200, 0);
        get_out("bias mid vector", 0, 0);
        wr_w(N, -128);
        wr_all(1);
        v = '{0, 0, 0, 0};
        send_vec(v, 0);
        get_out("bias neg", 0, 0);

        // Addresses above the bias slot must leave the bank untouched.
        wr_w(N, 0);
        wr_w(5, -128);
        wr_w(6, -128);
        wr_w(7, -128);
        v = '{200, 200, 200, 200};
        send_vec(v, 0);
        get_out("ignored addr", 0, 0);

        // Weight written in the same cycle as its element: old value used.
        wr_all(2);
        send_elem(0, 200, 0);
        in_valid  = 1'b1;
        in_data   = 8'd200;
        w_wr_en   = 1'b1;
        w_wr_addr = 3'd1;
        w_wr_data = 8'd50;
        chk("same-cycle in_ready", in_ready, 1);
        acc_m += 200 * w_m[1];
        tick();
        in_valid = 1'b0;
        w_wr_en  = 1'b0;
        w_m[1]   = 50;
        send_elem(2, 200, 0);
        send_elem(3, 200, 0);
        get_out("same-cycle old weight", 0, 0);
        send_vec(v, 0);
        get_out("same-cycle new weight", 0, 0);

        // Gapped input and a 5-cycle output stall with a pending source.
        for (int i = 0; i < N; i++) wr_w(i, i + 1);
        v = '{10, 20, 30, 40};
        for (int i = 0; i < N; i++) send_elem(i, v[i], 1);
        get_out("stall", 5, 1);
        v = '{3, 1, 4, 1};
        send_vec(v, 0);
        get_out("after stall", 0, 0);

        // Reset after two elements discards the vector and the weights.
        send_elem(0, 50, 0);
        send_elem(1, 60, 0);
        rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("mid reset out_valid", out_valid, 0);
            chk("mid reset out_data", out_data, 0);
            chk("mid reset in_ready", in_ready, 0);
            tick();
        end
        rst = 1'b0;
        model_reset();
        #1;
        chk("in_ready after mid reset", in_ready, 1);
        tick();
        v = '{1, 2, 3, 4};
        wr_all(1);
        send_vec(v, 0);
        get_out("after reset", 0, 0);

        // Randomized vectors, weights, bias, gaps and stalls.
        for (int r = 0; r < 30; r++) begin
            int wsel;
            wsel = int'($urandom_range(0, 2));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (wsel == 0) wr_w(i, int'($urandom_range(0, 255)) - 128);
                    else wr_w(i, int'($urandom_range(0, 15)) - 8);
                end
            end
            if ($urandom_range(0, 2) == 0) wr_w(N, int'($urandom_range(0, 255)) - 128);
            for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 255));
            send_vec(v, 2);
            get_out("random", int'($urandom_range(0, 3)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
